troop_digit_entry: RTL and testbench

- Serial decimal-to-binary troop-count entry; the inverse of the binary-to-BCD display conversion.
- Accepts up to MAX_DIGITS decimal digits, most significant first, via a valid/ready handshake, and accumulates them as value = value*10 + digit.
- On commit, presents the saturated binary troop count on a valid/ready output port.
- Sits between the player input decoder and the move/troop-split logic of the game core.

---
 rtl/troop_pkg.sv | 19 +
 rtl/bcd_sat_mac.sv | 23 ++
 rtl/troop_digit_entry.sv | 123 ++++++++++++
 tb/tb_troop_digit_entry.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/troop_pkg.sv
// Shared definitions for the troop-count entry path: widths, entry states and
// the decimal shift-add helper.
package troop_pkg;

  localparam int LOG2_MAX_TROOP = 9;
  localparam int MAX_TROOP      = (1 << LOG2_MAX_TROOP) - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_OUT   = 2'd2
  } entry_state_t;

  // acc*10 + digit without a multiplier; callers truncate to the width they need
  function automatic logic [31:0] mul10_add(input logic [31:0] acc, input logic [3:0] digit);
    return (acc << 3) + (acc << 1) + {28'd0, digit};
  endfunction

endpackage

// File: rtl/bcd_sat_mac.sv
// Combinational saturating acc*10 + digit; ovf flags a result above 2^W-1.
module bcd_sat_mac #(
  parameter int W = 9
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] next,
  output logic         ovf
);
  import troop_pkg::*;

  localparam logic [W+3:0] LIMIT = (W+4)'((1 << W) - 1);

  logic [W+3:0] sum;

  // W+4 bits always hold (2^W-1)*10 + 9, so the compare sees the true result
  always_comb begin
    sum  = (W+4)'(mul10_add(32'(acc), digit));
    ovf  = sum > LIMIT;
    next = ovf ? {W{1'b1}} : sum[W-1:0];
  end

endmodule

// File: rtl/troop_digit_entry.sv
// Serial decimal digit entry accumulating a saturated binary troop count,
// presented on a valid/ready port when the player commits.
//
// state   | meaning
// S_IDLE  | no legal digit held yet
// S_ENTRY | 1..MAX_DIGITS legal digits held
// S_OUT   | result presented on value, waiting for value_ready
module troop_digit_entry #(
  parameter int LOG2_MAX_TROOP = 9,
  parameter int MAX_DIGITS     = 3,
  localparam int CW            = $clog2(MAX_DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      digit_valid,
  input  logic [3:0]                digit,
  output logic                      digit_ready,
  input  logic                      commit,
  input  logic                      clear,
  output logic                      value_valid,
  output logic [LOG2_MAX_TROOP-1:0] value,
  input  logic                      value_ready,
  output logic                      overflow,
  output logic                      bad_digit,
  output logic [CW-1:0]             digit_count
);
  import troop_pkg::*;

  localparam int            W       = LOG2_MAX_TROOP;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  entry_state_t state, state_nxt;

  logic [W-1:0]  acc;
  logic [W-1:0]  mac_next;
  logic          mac_ovf;
  logic          legal;
  logic          accept;
  logic          take;
  logic          out_hs;
  logic [W-1:0]  acc_fold;
  logic [CW-1:0] cnt_fold;
  logic          ovf_fold;

  bcd_sat_mac #(.W(W)) u_mac (
    .acc   (acc),
    .digit (digit),
    .next  (mac_next),
    .ovf   (mac_ovf)
  );

  // a digit accepted in the commit cycle is folded in before value is latched
  always_comb begin
    legal    = digit <= 4'd9;
    accept   = digit_valid && digit_ready;
    take     = accept && legal;
    out_hs   = value_valid && value_ready;
    acc_fold = take ? mac_next : acc;
    cnt_fold = take ? digit_count + CW'(1) : digit_count;
    ovf_fold = overflow || (take && mac_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ENTRY: begin
          if (commit)    state_nxt = S_OUT;
          else if (take) state_nxt = S_ENTRY;
        end
        S_OUT:   if (out_hs) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    digit_ready = (state != S_OUT) && (digit_count < CNT_MAX) && !clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      bad_digit   <= 1'b0;
    end else if (clear) begin
      acc         <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      value_valid <= 1'b0;
      bad_digit   <= 1'b0;
    end else begin
      bad_digit <= accept && !legal;
      if (state == S_OUT) begin
        if (out_hs) begin
          acc         <= '0;
          digit_count <= '0;
          overflow    <= 1'b0;
          value_valid <= 1'b0;
        end
      end else begin
        acc         <= acc_fold;
        digit_count <= cnt_fold;
        overflow    <= ovf_fold;
        if (commit) begin
          value       <= acc_fold;
          value_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_troop_digit_entry.sv
// Scoreboard bench for troop_digit_entry: directed entries followed by random ones.
module tb_troop_digit_entry;
  localparam int W    = 9;
  localparam int MD   = 3;
  localparam int CW   = $clog2(MD + 1);
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          digit_valid = 1'b0;
  logic [3:0]    digit = 4'd0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic          value_ready = 1'b0;
  logic          digit_ready;
  logic          value_valid;
  logic [W-1:0]  value;
  logic          overflow;
  logic          bad_digit;
  logic [CW-1:0] digit_count;

  troop_digit_entry #(.LOG2_MAX_TROOP(W), .MAX_DIGITS(MD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .commit      (commit),
    .clear       (clear),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .overflow    (overflow),
    .bad_digit   (bad_digit),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    bit o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model of the entry in progress
  int m_val = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_bad = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && value_valid && value_ready && !clear) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got value %0d, expected no output", value);
      end else begin
        e = sb.pop_front();
        chk("sb_value", int'(value), e.v);
        chk("sb_overflow", int'(overflow), int'(e.o));
      end
    end
  end

  task automatic model_reset();
    m_val = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_bad = 1'b0;
  endtask

  // one cycle of digit/commit input while the entry is open
  task automatic drive(input bit dv, input int d, input bit cm);
    bit took;
    int nv;
    digit_valid = dv;
    digit       = 4'(d);
    commit      = cm;
    @(negedge clk);
    chk("digit_ready", int'(digit_ready), int'(m_cnt < MD));
    took  = dv && (m_cnt < MD);
    m_bad = took && (d > 9);
    if (took && d <= 9) begin
      nv = m_val * 10 + d;
      if (nv > MAXV) begin
        m_val = MAXV;
        m_ovf = 1'b1;
      end else begin
        m_val = nv;
      end
      m_cnt++;
    end
    if (cm) sb.push_back('{m_val, m_ovf});
    @(posedge clk);
    #1;
    chk("bad_digit", int'(bad_digit), int'(m_bad));
    chk("digit_count", int'(digit_count), m_cnt);
    chk("value_valid", int'(value_valid), int'(cm));
    digit_valid = 1'b0;
    commit      = 1'b0;
  endtask

  // hold the result for some cycles, then handshake or abort with clear
  task automatic finish(input int hold, input bit do_clear);
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      value_ready = 1'b0;
      commit      = 1'($urandom % 2);
      digit_valid = 1'($urandom % 2);
      digit       = 4'($urandom % 10);
      @(negedge clk);
      chk("ready_in_out", int'(digit_ready), 0);
      chk("hold_valid", int'(value_valid), 1);
      chk("hold_value", int'(value), m_val);
      chk("hold_overflow", int'(overflow), int'(m_ovf));
      @(posedge clk);
      #1;
    end
    commit      = 1'b0;
    digit_valid = 1'b0;
    if (do_clear) begin
      clear       = 1'b1;
      digit_valid = 1'b1;
      digit       = 4'd3;
      @(negedge clk);
      chk("ready_on_clear", int'(digit_ready), 0);
      e = sb.pop_back();
      @(posedge clk);
      #1;
      clear       = 1'b0;
      digit_valid = 1'b0;
    end else begin
      value_ready = 1'b1;
      @(posedge clk);
      #1;
      value_ready = 1'b0;
    end
    chk("post_valid", int'(value_valid), 0);
    chk("post_count", int'(digit_count), 0);
    chk("post_overflow", int'(overflow), 0);
    chk("post_bad", int'(bad_digit), 0);
    model_reset();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_valid"}, int'(value_valid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_bad"}, int'(bad_digit), 0);
    chk({tag, "_count"}, int'(digit_count), 0);
    chk({tag, "_ready"}, int'(digit_ready), 1);
  endtask

  initial begin
    int nd;
    int d;
    #1;
    chk_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1,2,3 -> 123
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0);
    drive(0, 0, 1);
    finish(0, 0);

    // 6,0,0 saturates; 5,1,1 lands exactly on the maximum
    drive(1, 6, 0); drive(1, 0, 0); drive(1, 0, 0);
    drive(0, 0, 1);
    finish(1, 0);
    drive(1, 5, 0); drive(1, 1, 0); drive(1, 1, 0);
    drive(0, 0, 1);
    finish(0, 0);

    // illegal digit in the middle, last digit together with commit
    drive(1, 4, 0); drive(1, 11, 0); drive(1, 2, 1);
    finish(2, 0);

    // fourth digit stays pending while the entry is full
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0);
    drive(1, 4, 0); drive(1, 4, 1);
    finish(0, 0);

    // commit with zero digits
    drive(0, 0, 1);
    finish(1, 0);

    // result held while the consumer stalls, then aborted by clear
    drive(1, 7, 1);
    finish(5, 1);

    // asynchronous reset mid-entry
    drive(1, 9, 0); drive(1, 9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    rst_n = 1'b1;
    model_reset();
    drive(1, 5, 0);
    drive(0, 0, 1);
    finish(0, 0);

    for (int t = 0; t < 60; t++) begin
      nd = $urandom_range(0, 5);
      for (int k = 0; k < nd; k++) begin
        d = ($urandom % 8 == 0) ? 10 + int'($urandom % 6) : int'($urandom % 10);
        drive(($urandom % 4) != 0, d, 0);
      end
      d = ($urandom % 8 == 0) ? 10 + int'($urandom % 6) : int'($urandom % 10);
      drive(($urandom % 2) != 0, d, 1);
      finish($urandom_range(0, 3), ($urandom % 8) == 0);
    end

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
